cu_seq: RTL and testbench
=========================

Name: cu_seq

Overview:
- Sequenced, parametrised successor of the autoencoder control unit.
- Accepts one opcode per valid/ready handshake, decodes it, and drives registered control strobes for as many cycles as the operation needs.
- Supports multi-cycle multiply and LUT operations, an output stage that waits on downstream ready, NOP, and sticky illegal-opcode detection.
- Sits between the instruction source and the ALU/memory/LUT datapath.

Parameters:
- OP_WIDTH, 4, opcode width; must be >= 4. Any set bit above bit 3 makes the opcode illegal.
- MUL_LAT, 3, cycles the multiply occupies the ALU; must be >= 1.
- LUT_LAT, 2, cycles a sigmoid or sigmoid-diff LUT lookup occupies; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  opcode presented
- opcode  in  OP_WIDTH  operation code
- instr_ready  out  1  CU can accept an opcode this cycle
- en_alu  out  1  ALU enable
- op_sel  out  2  ALU op: 00 add, 01 sub, 10 mul
- en_writeMem  out  1  memory write commit strobe
- en_selMem  out  1  memory select
- dest_control  out  2  result route: 00 mem, 01 sigmoid, 10 relu, 11 sigmoid-diff
- oprnd2_sel  out  1  operand-2 mux select
- en_out  out  1  output-valid to downstream
- out_ready  in  1  downstream accepts output
- done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  instruction in flight
- err_illegal  out  1  sticky illegal-opcode flag
- err_clr  in  1  clears err_illegal

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE and the latency counter is cleared.
  - All registered outputs are 0: en_alu, op_sel, en_writeMem, en_selMem, dest_control, oprnd2_sel, en_out, done, busy, err_illegal.
  - instr_ready=1 after reset.
- Reset mid-operation aborts the instruction. No done pulse and no write strobe are produced.
- Accept: an opcode is taken when instr_valid && instr_ready. Its control outputs appear on the next cycle, so latency is 1 cycle.
- instr_ready is combinational from state and counter only, never from instr_valid. It is 1 in IDLE and on the retiring cycle of a non-output op, which allows back-to-back issue.
- FSM states:
  - IDLE → EXEC on accept.
  - EXEC → IDLE at retire with no new accept, or stays in EXEC (reloaded) when a new opcode is accepted on the retire cycle.
  - EXEC → OUTW for opcode 8.
  - OUTW → IDLE when out_ready=1.
- Opcodes and per-op behaviour:
  - 0 add, 1 sub, 2 mul: en_alu=1, op_sel=00/01/10 held for 1, 1 and MUL_LAT cycles respectively. en_writeMem=1 only on the last cycle.
  - 3: en_writeMem=1 for 1 cycle.
  - 4: en_selMem=1 for 1 cycle; no write.
  - 5 sigmoid, 7 sigmoid-diff: en_alu=1, oprnd2_sel=1, dest_control=01/11 held for LUT_LAT cycles. en_writeMem=1 on the last cycle.
  - 6 relu: en_alu=1, oprnd2_sel=1, dest_control=10, en_writeMem=1, all for 1 cycle.
  - 8 output: en_alu=1, oprnd2_sel=1, en_out=1, held until the cycle out_ready=1 (inclusive). instr_ready stays 0 throughout.
  - F NOP: one EXEC cycle with all control outputs 0; done pulses.
  - Any other value, including upper bits set: treated as NOP and err_illegal is set.
- Any control field not listed for an active op is 0. All controls drop to 0 in the cycle after retire unless a new op was accepted.
- done=1 on the retire cycle, which is the cycle of en_writeMem for write ops and the cycle out_ready=1 for output.
- busy=1 in EXEC and OUTW.
- err_illegal is sticky until err_clr=1. If err_clr and a new illegal accept occur in the same cycle, the set wins.
- The latency counter is sized clog2(max(MUL_LAT, LUT_LAT))+1 and loads lat-1 on accept, decrementing to 0. No wrap is possible.
- opcode is sampled only on accept. Changes while not accepted are ignored.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (OPC_ADD … OPC_OUT, OPC_NOP)
  - op_sel codes and dest_control codes
  - the FSM state encoding (IDLE, EXEC, OUTW)
  - a packed control-vector struct
- Sub-module cu_decode is combinational. It maps an opcode to the control vector, a latency class (1, MUL, LUT, OUT) and an illegal flag. cu_seq registers its outputs.

Test Plan:
- Reset: hold rst_n=0, then release → all outputs 0, instr_ready=1. Assert rst_n=0 in cycle 2 of a mul → outputs 0 immediately, no done pulse.
- Add accepted at cycle 0, sub at cycle 1 (back-to-back) → cycle 1: en_alu=1, op_sel=00, en_writeMem=1, done=1. Cycle 2: op_sel=01, en_writeMem=1, done=1. Cycle 3: all 0.
- Mul (0x2), MUL_LAT=3 → cycles 1-3: en_alu=1, op_sel=10. en_writeMem and done only in cycle 3. instr_ready=0 in cycles 1-2 and 1 in cycle 3.
- Sigmoid (0x5), LUT_LAT=2 → cycles 1-2: dest_control=01, oprnd2_sel=1, en_alu=1. en_writeMem only in cycle 2.
- Output (0x8) with out_ready=0 for 4 cycles then 1 → en_out=1 in cycles 1-5, done in cycle 5, instr_ready=0 in cycles 1-5.
- Opcode 0x9, then 0x10 with OP_WIDTH=6 → no control outputs, done pulses, err_illegal=1 and held. err_clr → 0. err_clr coincident with an illegal accept → stays 1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the sequenced control unit: opcodes, control codes,
// FSM encoding, latency classes and the packed control vector.
package cu_pkg;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_MUL  = 4'h2;
  localparam logic [3:0] OPC_WR   = 4'h3;
  localparam logic [3:0] OPC_SEL  = 4'h4;
  localparam logic [3:0] OPC_SIG  = 4'h5;
  localparam logic [3:0] OPC_RELU = 4'h6;
  localparam logic [3:0] OPC_SIGD = 4'h7;
  localparam logic [3:0] OPC_OUT  = 4'h8;
  localparam logic [3:0] OPC_NOP  = 4'hF;

  localparam logic [1:0] OPS_ADD = 2'b00;
  localparam logic [1:0] OPS_SUB = 2'b01;
  localparam logic [1:0] OPS_MUL = 2'b10;

  localparam logic [1:0] DST_MEM  = 2'b00;
  localparam logic [1:0] DST_SIG  = 2'b01;
  localparam logic [1:0] DST_RELU = 2'b10;
  localparam logic [1:0] DST_SIGD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_OUTW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_LUT = 2'd2,
    LAT_OUT = 2'd3
  } lat_class_t;

  // wr marks an op that commits to memory on its last cycle
  typedef struct packed {
    logic       en_alu;
    logic [1:0] op_sel;
    logic       wr;
    logic       en_selMem;
    logic [1:0] dest_control;
    logic       oprnd2_sel;
    logic       en_out;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: control vector, latency class and illegal flag.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output ctrl_t               ctrl,
  output lat_class_t          cls,
  output logic                illegal
);

  logic       hi_s;
  logic [3:0] lo_s;

  assign hi_s = |(opcode >> 3'd4);
  assign lo_s = opcode[3:0];

  // opcode to control vector; anything unrecognised decodes as a flagged NOP
  always_comb begin
    ctrl    = '0;
    cls     = LAT_ONE;
    illegal = 1'b0;
    if (hi_s) begin
      illegal = 1'b1;
    end else begin
      case (lo_s)
        OPC_ADD: begin
          ctrl.en_alu = 1'b1;
          ctrl.op_sel = OPS_ADD;
          ctrl.wr     = 1'b1;
        end
        OPC_SUB: begin
          ctrl.en_alu = 1'b1;
          ctrl.op_sel = OPS_SUB;
          ctrl.wr     = 1'b1;
        end
        OPC_MUL: begin
          ctrl.en_alu = 1'b1;
          ctrl.op_sel = OPS_MUL;
          ctrl.wr     = 1'b1;
          cls         = LAT_MUL;
        end
        OPC_WR:  ctrl.wr = 1'b1;
        OPC_SEL: ctrl.en_selMem = 1'b1;
        OPC_SIG, OPC_SIGD: begin
          ctrl.en_alu       = 1'b1;
          ctrl.oprnd2_sel   = 1'b1;
          ctrl.dest_control = (lo_s == OPC_SIG) ? DST_SIG : DST_SIGD;
          ctrl.wr           = 1'b1;
          cls               = LAT_LUT;
        end
        OPC_RELU: begin
          ctrl.en_alu       = 1'b1;
          ctrl.oprnd2_sel   = 1'b1;
          ctrl.dest_control = DST_RELU;
          ctrl.wr           = 1'b1;
        end
        OPC_OUT: begin
          ctrl.en_alu     = 1'b1;
          ctrl.oprnd2_sel = 1'b1;
          ctrl.en_out     = 1'b1;
          cls             = LAT_OUT;
        end
        OPC_NOP: ctrl = '0;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cu_seq.sv
// Sequenced control unit: accepts one opcode per handshake and drives
// registered control strobes for the duration of the operation.
module cu_seq
  import cu_pkg::*;
#(
  parameter int OP_WIDTH = 4,
  parameter int MUL_LAT  = 3,
  parameter int LUT_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OP_WIDTH-1:0] opcode,
  output logic                instr_ready,
  output logic                en_alu,
  output logic [1:0]          op_sel,
  output logic                en_writeMem,
  output logic                en_selMem,
  output logic [1:0]          dest_control,
  output logic                oprnd2_sel,
  output logic                en_out,
  input  logic                out_ready,
  output logic                done,
  output logic                busy,
  output logic                err_illegal,
  input  logic                err_clr
);

  localparam int LAT_MAX = (MUL_LAT > LUT_LAT) ? MUL_LAT : LUT_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX) + 1;
  localparam logic [CNT_W-1:0] MUL_M1  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LUT_M1  = CNT_W'(LUT_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r, state_nxt;
  lat_class_t       cls_r, cls_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  ctrl_t            ctrl_r, ctrl_nxt;
  logic             we_r, we_nxt;
  logic             done_r, done_nxt;
  logic             busy_r, busy_nxt;
  logic             err_r, err_nxt;

  ctrl_t            dec_ctrl_s;
  lat_class_t       dec_cls_s;
  logic             dec_illegal_s;
  logic [CNT_W-1:0] ld_cnt_s;
  logic             ld_we_s;
  logic             ld_done_s;
  logic             ready_s;
  logic             accept_s;

  cu_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl_s),
    .cls     (dec_cls_s),
    .illegal (dec_illegal_s)
  );

  // first-cycle values of a freshly accepted opcode
  always_comb begin
    case (dec_cls_s)
      LAT_MUL: ld_cnt_s = MUL_M1;
      LAT_LUT: ld_cnt_s = LUT_M1;
      default: ld_cnt_s = '0;
    endcase
    ld_we_s   = dec_ctrl_s.wr && (ld_cnt_s == '0);
    ld_done_s = (dec_cls_s != LAT_OUT) && (ld_cnt_s == '0);
  end

  assign ready_s  = (state_r == ST_IDLE) ||
                    ((state_r == ST_EXEC) && (cls_r != LAT_OUT) && (cnt_r == '0));
  assign accept_s = instr_valid && ready_s;

  // next-state and next-output logic
  always_comb begin
    state_nxt = state_r;
    cls_nxt   = cls_r;
    cnt_nxt   = cnt_r;
    ctrl_nxt  = '0;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt = ST_EXEC;
          cls_nxt   = dec_cls_s;
          cnt_nxt   = ld_cnt_s;
          ctrl_nxt  = dec_ctrl_s;
          we_nxt    = ld_we_s;
          done_nxt  = ld_done_s;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cls_r == LAT_OUT) begin
          if (out_ready) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_OUTW;
            ctrl_nxt  = ctrl_r;
          end
        end else if (cnt_r != '0) begin
          cnt_nxt  = cnt_r - CNT_ONE;
          ctrl_nxt = ctrl_r;
          we_nxt   = ctrl_r.wr && (cnt_r == CNT_ONE);
          done_nxt = (cnt_r == CNT_ONE);
        end else if (accept_s) begin
          state_nxt = ST_EXEC;
          cls_nxt   = dec_cls_s;
          cnt_nxt   = ld_cnt_s;
          ctrl_nxt  = dec_ctrl_s;
          we_nxt    = ld_we_s;
          done_nxt  = ld_done_s;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OUTW: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          ctrl_nxt = ctrl_r;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (accept_s && dec_illegal_s) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end else begin
      err_nxt = err_r;
    end
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cls_r   <= LAT_ONE;
      cnt_r   <= '0;
      ctrl_r  <= '0;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cls_r   <= cls_nxt;
      cnt_r   <= cnt_nxt;
      ctrl_r  <= ctrl_nxt;
      we_r    <= we_nxt;
      done_r  <= done_nxt;
      busy_r  <= busy_nxt;
      err_r   <= err_nxt;
    end
  end

  assign instr_ready  = ready_s;
  assign en_alu       = ctrl_r.en_alu;
  assign op_sel       = ctrl_r.op_sel;
  assign en_writeMem  = we_r;
  assign en_selMem    = ctrl_r.en_selMem;
  assign dest_control = ctrl_r.dest_control;
  assign oprnd2_sel   = ctrl_r.oprnd2_sel;
  assign en_out       = ctrl_r.en_out;
  // an output op retires in the very cycle downstream takes it
  assign done         = done_r | (ctrl_r.en_out & out_ready);
  assign busy         = busy_r;
  assign err_illegal  = err_r;

endmodule

// File: tb/tb_cu_seq.sv
// Directed self-checking bench for cu_seq with hand-computed expected vectors.
module tb_cu_seq;

  localparam int OPW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           instr_valid;
  logic [OPW-1:0] opcode;
  logic           instr_ready;
  logic           en_alu;
  logic [1:0]     op_sel;
  logic           en_writeMem;
  logic           en_selMem;
  logic [1:0]     dest_control;
  logic           oprnd2_sel;
  logic           en_out;
  logic           out_ready;
  logic           done;
  logic           busy;
  logic           err_illegal;
  logic           err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cu_seq #(.OP_WIDTH(OPW), .MUL_LAT(3), .LUT_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .instr_ready  (instr_ready),
    .en_alu       (en_alu),
    .op_sel       (op_sel),
    .en_writeMem  (en_writeMem),
    .en_selMem    (en_selMem),
    .dest_control (dest_control),
    .oprnd2_sel   (oprnd2_sel),
    .en_out       (en_out),
    .out_ready    (out_ready),
    .done         (done),
    .busy         (busy),
    .err_illegal  (err_illegal),
    .err_clr      (err_clr)
  );

  // {ir, alu, op_sel, we, sel, dest, o2, en_out, done, busy, err}
  function automatic logic [15:0] ev(input logic ir, input logic alu, input logic [1:0] ops,
                                     input logic we, input logic sel, input logic [1:0] dst,
                                     input logic o2, input logic eo, input logic dn,
                                     input logic bz, input logic er);
    return {3'b000, ir, alu, ops, we, sel, dst, o2, eo, dn, bz, er};
  endfunction

  function automatic logic [15:0] obs();
    return {3'b000, instr_ready, en_alu, op_sel, en_writeMem, en_selMem, dest_control,
            oprnd2_sel, en_out, done, busy, err_illegal};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to the next cycle, drive its inputs, then settle at mid-cycle
  task automatic cyc(input logic v, input logic [OPW-1:0] opc, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    instr_valid = v;
    opcode      = opc;
    out_ready   = ordy;
    err_clr     = clr;
    @(negedge clk);
  endtask

  logic [15:0] idle0, idle1;

  initial begin
    idle0 = ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1 = ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    out_ready   = 1'b0;
    err_clr     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", obs(), idle0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", obs(), idle0);

    // add then sub back-to-back
    cyc(1'b1, 6'h00, 1'b0, 1'b0);
    check("add_c0", obs(), idle0);
    cyc(1'b1, 6'h01, 1'b0, 1'b0);
    check("add_c1", obs(), ev(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sub_c2", obs(), ev(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("addsub_c3", obs(), idle0);

    // mul; a valid sub offered while not ready must be ignored
    cyc(1'b1, 6'h02, 1'b0, 1'b0);
    cyc(1'b1, 6'h01, 1'b0, 1'b0);
    check("mul_c1", obs(), ev(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("mul_c2", obs(), ev(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("mul_c3", obs(), ev(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("mul_c4", obs(), idle0);

    // sigmoid
    cyc(1'b1, 6'h05, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sig_c1", obs(), ev(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sig_c2", obs(), ev(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sig_c3", obs(), idle0);

    // write, select, relu, sigmoid-diff chained
    cyc(1'b1, 6'h03, 1'b0, 1'b0);
    cyc(1'b1, 6'h04, 1'b0, 1'b0);
    check("wr_c1", obs(), ev(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b1, 6'h06, 1'b0, 1'b0);
    check("sel_c2", obs(), ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b1, 6'h07, 1'b0, 1'b0);
    check("relu_c3", obs(), ev(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sigd_c4", obs(), ev(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("sigd_c5", obs(), ev(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("chain_c6", obs(), idle0);

    // output op waiting four cycles on downstream
    cyc(1'b1, 6'h08, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 6'h00, 1'b0, 1'b0);
      check($sformatf("out_wait_c%0d", i), obs(),
            ev(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    end
    cyc(1'b0, 6'h00, 1'b1, 1'b0);
    check("out_c5", obs(), ev(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("out_c6", obs(), idle0);

    // illegal opcodes, sticky flag, clear, clear vs set
    cyc(1'b1, 6'h09, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("ill9_c1", obs(), ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(1'b1, 6'h10, 1'b0, 1'b0);
    check("ill9_idle", obs(), idle1);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("ill10_c1", obs(), ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("err_held", obs(), idle1);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    check("err_clr_cycle", obs(), idle1);
    cyc(1'b1, 6'h0F, 1'b0, 1'b0);
    check("err_cleared", obs(), idle0);
    cyc(1'b1, 6'h09, 1'b0, 1'b1);
    check("nop_c1", obs(), ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("set_beats_clr", obs(), ev(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("err_held2", obs(), idle1);

    // reset during cycle 2 of a mul
    cyc(1'b1, 6'h02, 1'b0, 1'b0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("mul2_c1", obs(), ev(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_now", obs(), idle0);
    @(negedge clk);
    check("rst_mid_c2", obs(), idle0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_c3", obs(), idle0);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);
    check("rst_mid_c4", obs(), idle0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
